// File: rtl/sm_conv_pkg.sv
// Shared definitions for the sign-magnitude converter arbiter: data width,
// saturation constants and the arbiter FSM state encoding.
package sm_conv_pkg;

  localparam int DATA_W = 11;

  // The most negative 11-bit value has no sign-magnitude image and is clamped.
  localparam logic [DATA_W-1:0] SAT_IN  = 11'h400;
  localparam logic [DATA_W-1:0] SAT_OUT = 11'h3FF;

  // RSVD is never entered on purpose; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2,
    RSVD = 2'd3
  } state_t;

endpackage

// File: rtl/twoc_to_sm.sv
// Combinational two's-complement to sign-magnitude converter.
// The most negative input comes out with magnitude 11'h400; callers that need
// a representable result clamp that case themselves.
module twoc_to_sm
  import sm_conv_pkg::*;
(
  input  logic [DATA_W-1:0] t,
  output logic [DATA_W-1:0] sm,
  output logic              signbit
);

  // Negate negative inputs, pass positive ones through.
  always_comb begin
    signbit = t[DATA_W-1];
    sm      = signbit ? (~t + 1'b1) : t;
  end

endmodule

// File: rtl/sm_conv_arbiter.sv
// Round-robin arbiter sharing one two's-complement -> sign-magnitude converter
// between NREQ requesters. One operand is captured per grant, converted, and
// returned with the winner's index.
//
// Handshakes:
//   Request side: req[i] is held with a stable operand until ack[i] pulses for
//   one cycle; req is only looked at while the FSM is IDLE.
//   Result side: out_valid stays high with out_* stable until a cycle in which
//   out_valid & out_ready are both 1; that cycle is the transfer, and out_valid
//   drops on the following edge.
module sm_conv_arbiter
  import sm_conv_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_sm,
  output logic                   out_sign,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_sat,
  output logic [1:0]             state_dbg
);

  localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   op_reg;
  logic [ID_W-1:0]     id_reg;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     win;
  logic                found;
  logic [ID_W:0]       cand;
  logic [DATA_W-1:0]   ops [NREQ];
  logic [DATA_W-1:0]   conv_sm;
  logic                conv_sign;
  logic                conv_sat;

  logic [NREQ-1:0]     ack_d;
  logic                busy_d;
  logic                valid_d;
  logic [DATA_W-1:0]   sm_d;
  logic                sign_d;
  logic [ID_W-1:0]     id_d;
  logic                sat_d;

  assign state_dbg = state;

  // Split the flat operand bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ops[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: first active request at or after rr_ptr, wrapping.
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  twoc_to_sm u_conv (
    .t       (op_reg),
    .sm      (conv_sm),
    .signbit (conv_sign)
  );

  assign conv_sat = (op_reg == SAT_IN);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: capture, convert, then wait for the result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = CONV;
      CONV:    state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ack_d   = '0;
    busy_d  = (state_nxt != IDLE);
    valid_d = out_valid;
    sm_d    = out_sm;
    sign_d  = out_sign;
    id_d    = out_id;
    sat_d   = out_sat;
    case (state)
      IDLE: if (|req) ack_d[win] = 1'b1;
      CONV: begin
        valid_d = 1'b1;
        sm_d    = conv_sat ? SAT_OUT : conv_sm;
        sign_d  = conv_sat ? 1'b0 : conv_sign;
        id_d    = id_reg;
        sat_d   = conv_sat;
      end
      HOLD:    if (out_ready) valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_sm    <= '0;
      out_sign  <= 1'b0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else begin
      ack       <= ack_d;
      busy      <= busy_d;
      out_valid <= valid_d;
      out_sm    <= sm_d;
      out_sign  <= sign_d;
      out_id    <= id_d;
      out_sat   <= sat_d;
    end
  end

  // Operand capture on grant and pointer advance past the served requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg <= '0;
      id_reg <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && |req) begin
        op_reg <= ops[win];
        id_reg <= win;
      end
      if (state == CONV) begin
        rr_ptr <= (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sm_conv_arbiter.sv
// Bench for sm_conv_arbiter: directed vector table, round-robin, backpressure,
// reset and NREQ=3 wrap sequences, then random traffic against a reference model.
module tb_sm_conv_arbiter;
  import sm_conv_pkg::*;

  localparam int NREQ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NREQ=4 instance
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        ack;
  logic                   busy, out_valid;
  logic                   out_ready = 1'b0;
  logic [DATA_W-1:0]      out_sm;
  logic                   out_sign, out_sat;
  logic [1:0]             out_id;
  logic [1:0]             state_dbg;

  // NREQ=3 instance
  logic [2:0]             req3 = '0;
  logic [3*DATA_W-1:0]    req_data3 = '0;
  logic [2:0]             ack3;
  logic                   busy3, valid3, sign3, sat3;
  logic                   ready3 = 1'b0;
  logic [DATA_W-1:0]      sm3;
  logic [1:0]             id3;
  logic [1:0]             state3;

  sm_conv_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_sm(out_sm), .out_sign(out_sign),
    .out_id(out_id), .out_sat(out_sat), .state_dbg(state_dbg)
  );

  sm_conv_arbiter #(.NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .ack(ack3), .busy(busy3),
    .out_valid(valid3), .out_ready(ready3), .out_sm(sm3), .out_sign(sign3),
    .out_id(id3), .out_sat(sat3), .state_dbg(state3)
  );

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [14:0] exp_q[$];   // {id, sat, sign, sm}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {11'b0, ack, busy, out_valid, out_sm, out_sign, out_id, out_sat};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [3:0] a, input logic b, input logic v,
                                           input logic [10:0] sm, input logic sg,
                                           input logic [1:0] id, input logic st);
    return {11'b0, a, b, v, sm, sg, id, st};
  endfunction

  // Reference conversion from plain integer arithmetic: {sm, sign, sat}.
  function automatic logic [12:0] ref_conv(input logic [10:0] t);
    int v;
    int mag;
    v = int'($signed(t));
    if (v == -1024) return {11'h3FF, 1'b0, 1'b1};
    mag = (v < 0) ? -v : v;
    return {mag[10:0], (v < 0), 1'b0};
  endfunction

  function automatic int oh_idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  function automatic logic [10:0] rand_operand();
    case ($urandom_range(0, 9))
      0: return 11'h400;
      1: return 11'h7FF;
      2: return 11'h000;
      3: return 11'h3FF;
      4: return 11'h401;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end at the drive point: 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1; req = '0; req3 = '0; out_ready = 1'b0; ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [43:0] data;
    logic [1:0]  id;
    logic [10:0] sm;
    logic        sign;
    logic        sat;
  } vec_t;

  // One transaction from idle with out_ready=1, checking exact timing.
  task automatic run_txn(input vec_t v, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << v.id;
    req = v.req; req_data = v.data; out_ready = 1'b1;
    @(negedge clk);
    check({nm, " idle"}, {ack, busy, out_valid}, 6'b0);
    @(negedge clk);
    check({nm, " ack"}, {ack, busy, out_valid}, {oh, 1'b1, 1'b0});
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check({nm, " result"}, pack_out(), pack_exp(4'b0, 1'b1, 1'b1, v.sm, v.sign, v.id, v.sat));
    @(negedge clk);
    check({nm, " after"}, pack_out(), pack_exp(4'b0, 1'b0, 1'b0, v.sm, v.sign, v.id, v.sat));
    @(posedge clk); #1;
  endtask

  task automatic run3(input logic [2:0] r, input logic [32:0] d, input logic [1:0] id,
                      input logic [10:0] sm, input logic sg, input string nm);
    req3 = r; req_data3 = d; ready3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({nm, " ack"}, {29'b0, ack3}, {29'b0, 3'b001 << id});
    @(posedge clk); #1 req3 = '0;
    @(negedge clk);
    check({nm, " result"}, {valid3, id3, sm3, sign3, sat3}, {1'b1, id, sm, sg, 1'b0});
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- reference model for random traffic ----------------
  logic [3:0]  m_ack;
  logic        m_busy, m_valid, m_pend, m_sign, m_sat;
  logic [10:0] m_sm, m_op;
  logic [1:0]  m_id;
  int          m_rr, m_wid;

  task automatic model_reset();
    m_ack = '0; m_busy = 0; m_valid = 0; m_pend = 0; m_sign = 0; m_sat = 0;
    m_sm = '0; m_op = '0; m_id = '0; m_rr = 0; m_wid = 0;
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    logic [12:0] r;
    if (m_pend) begin
      r = ref_conv(m_op);
      m_ack = '0; m_pend = 0; m_valid = 1;
      m_sm = r[12:2]; m_sign = r[1]; m_sat = r[0]; m_id = 2'(m_wid);
      m_rr = (m_wid + 1) % NREQ;
      exp_q.push_back({2'(m_wid), r[0], r[1], r[12:2]});
    end else if (m_valid) begin
      if (out_ready) begin m_valid = 0; m_busy = 0; end
    end else if (req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int p;
        p = (m_rr + k) % NREQ;
        if (req[p]) begin m_wid = p; break; end
      end
      m_op = req_data[m_wid*DATA_W +: DATA_W];
      m_ack = 4'b0001 << m_wid; m_pend = 1; m_busy = 1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main test ----------------
  vec_t vecs[8];
  int   ids[8];
  int   tms[8];
  int   ngr, cyc;
  logic [3:0] last_ack, ack_seen;

  initial begin
    vecs[0] = '{4'b0100, {11'h000, 11'h7FF, 11'h000, 11'h000}, 2'd2, 11'h001, 1'b1, 1'b0};
    vecs[1] = '{4'b0001, {11'h000, 11'h000, 11'h000, 11'h400}, 2'd0, 11'h3FF, 1'b0, 1'b1};
    vecs[2] = '{4'b0001, {11'h000, 11'h000, 11'h000, 11'h123}, 2'd0, 11'h123, 1'b0, 1'b0};
    vecs[3] = '{4'b1001, {11'h001, 11'h000, 11'h000, 11'h7FF}, 2'd3, 11'h001, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, {11'h055, 11'h044, 11'h033, 11'h000}, 2'd0, 11'h000, 1'b0, 1'b0};
    vecs[5] = '{4'b0101, {11'h000, 11'h401, 11'h000, 11'h222}, 2'd2, 11'h3FF, 1'b1, 1'b0};
    vecs[6] = '{4'b0110, {11'h000, 11'h111, 11'h3FF, 11'h000}, 2'd1, 11'h3FF, 1'b0, 1'b0};
    vecs[7] = '{4'b1000, {11'h600, 11'h000, 11'h000, 11'h000}, 2'd3, 11'h200, 1'b1, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset outputs", pack_out(), 32'd0);
    check("reset state", {30'b0, state_dbg}, 32'd0);
    check("reset outputs n3", {ack3, busy3, valid3, sm3, sign3, id3, sat3, state3}, 32'd0);
    @(posedge clk); #1;

    // Directed vector table (rr pointer carried through in order)
    for (int v = 0; v < 8; v++) run_txn(vecs[v], $sformatf("vec%0d", v));

    // Round-robin with all ports requesting
    do_reset();
    out_ready = 1'b1;
    req_data = {11'h004, 11'h003, 11'h002, 11'h001};
    req = 4'hF; ngr = 0; cyc = 0;
    while (ngr < 6 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (ack != 0) begin ids[ngr] = oh_idx(ack); tms[ngr] = cyc; ngr++; end
      last_ack = ack;
      @(posedge clk); #1 req = 4'hF & ~last_ack;
    end
    req = '0;
    check("rr grant count", ngr, 6);
    for (int g = 0; g < ngr; g++) begin
      check($sformatf("rr id%0d", g), ids[g], g % 4);
      if (g > 0) check($sformatf("rr spacing%0d", g), tms[g] - tms[g-1], 3);
    end

    // Backpressure
    do_reset();
    req = 4'b0011; req_data = {11'h000, 11'h000, 11'h7F0, 11'h005}; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp ack0", {ack, busy}, {4'b0001, 1'b1});
    @(posedge clk); #1 req = 4'b0010;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check($sformatf("bp stall%0d", s), pack_out(), pack_exp(4'b0, 1'b1, 1'b1, 11'h005, 1'b0, 2'd0, 1'b0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp handshake", pack_out(), pack_exp(4'b0, 1'b1, 1'b1, 11'h005, 1'b0, 2'd0, 1'b0));
    @(negedge clk);
    check("bp idle", {ack, busy, out_valid}, 6'b0);
    @(negedge clk);
    check("bp ack1", {ack, busy}, {4'b0010, 1'b1});
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("bp result1", pack_out(), pack_exp(4'b0, 1'b1, 1'b1, 11'h010, 1'b1, 2'd1, 1'b0));
    @(negedge clk);
    @(posedge clk); #1;

    // Reset during CONV
    do_reset();
    run_txn('{4'b0010, {11'h0, 11'h0, 11'h00A, 11'h0}, 2'd1, 11'h00A, 1'b0, 1'b0}, "rc pre");
    req = 4'b0100; req_data = {11'h0, 11'h7FF, 11'h0, 11'h0};
    @(negedge clk);
    @(negedge clk);
    check("rc ack", {28'b0, ack}, 32'b0100);
    rst = 1'b1; req = '0;
    #1 check("rc async", pack_out(), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("rc quiet%0d", s), {ack, out_valid}, 5'b0);
    end
    @(posedge clk); #1;
    run_txn('{4'b1111, {11'h7FD, 11'h7FE, 11'h7FF, 11'h00C}, 2'd0, 11'h00C, 1'b0, 1'b0}, "rc rr0");

    // Reset during HOLD
    req = 4'b0010; req_data = {11'h0, 11'h0, 11'h050, 11'h0}; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("rh hold", {out_valid, out_id}, {1'b1, 2'd1});
    rst = 1'b1;
    #1 check("rh async", pack_out(), 32'd0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("rh quiet%0d", s), {ack, out_valid}, 5'b0);
    end
    @(posedge clk); #1;
    run_txn('{4'b1001, {11'h020, 11'h0, 11'h0, 11'h030}, 2'd0, 11'h030, 1'b0, 1'b0}, "rh rr0");

    // NREQ=3 wrap
    do_reset();
    run3(3'b001, {11'h000, 11'h000, 11'h002}, 2'd0, 11'h002, 1'b0, "n3 p0");
    run3(3'b101, {11'h010, 11'h000, 11'h7FE}, 2'd2, 11'h010, 1'b0, "n3 wrap p2");
    run3(3'b011, {11'h010, 11'h005, 11'h7FE}, 2'd0, 11'h002, 1'b1, "n3 then p0");

    // Random traffic against the reference model
    do_reset();
    model_reset();
    exp_q.delete();
    ack_seen = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack_seen[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = rand_operand();
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      check($sformatf("rand cyc%0d", c), pack_out(),
            pack_exp(m_ack, m_busy, m_valid, m_sm, m_sign, m_id, m_sat));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rand result cyc%0d: got unexpected result, expected none", c);
        end else begin
          check($sformatf("rand result cyc%0d", c), {out_id, out_sat, out_sign, out_sm}, exp_q.pop_front());
        end
      end
      ack_seen = ack;
      model_step();
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
